// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the inter-stage pipeline register.
// Optional skid buffer is enabled with PIPE_SKID_BUF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } stage_st_t;

    localparam int IF_ID_CTRL_W  = 2;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 12;
    localparam int ID_EX_DATA_W  = 149;
    localparam int EX_MEM_CTRL_W = 6;
    localparam int EX_MEM_DATA_W = 108;
    localparam int MEM_WB_CTRL_W = 3;
    localparam int MEM_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry stage (main + skid) with a registered ready.
// Built into pipe_stage_reg only when PIPE_SKID_BUF_EN is defined.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W   = 161,
    parameter bit CLR = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_bus,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_bus
);

    stage_st_t r_st;
    stage_st_t w_st_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic w_acc;
    logic w_drn;
    logic w_ld_main;
    logic w_ld_skid;
    logic w_mv;

    always_comb begin
        w_acc     = i_valid & (r_st != ST_FULL);
        w_drn     = (r_st != ST_EMPTY) & i_ready;
        w_st_nxt  = r_st;
        w_ld_main = 1'b0;
        w_ld_skid = 1'b0;
        w_mv      = 1'b0;
        unique case (r_st)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_st_nxt  = ST_ONE;
                    w_ld_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc & ~w_drn) begin
                    w_st_nxt  = ST_FULL;
                    w_ld_skid = 1'b1;
                end else if (w_drn & ~w_acc) begin
                    w_st_nxt = ST_EMPTY;
                end else if (w_acc & w_drn) begin
                    w_ld_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drn) begin
                    w_st_nxt = ST_ONE;
                    w_mv     = 1'b1;
                end
            end
            default: w_st_nxt = ST_EMPTY;
        endcase
        // flush wins over every transfer, including one accepted this cycle
        if (i_flush) begin
            w_st_nxt  = ST_EMPTY;
            w_ld_main = 1'b0;
            w_ld_skid = 1'b0;
            w_mv      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st <= ST_EMPTY;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main <= '0;
        end else if (i_flush) begin
            if (CLR) begin
                r_main <= '0;
            end
        end else if (w_ld_main) begin
            r_main <= i_bus;
        end else if (w_mv) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skid <= '0;
        end else if (w_ld_skid) begin
            r_skid <= i_bus;
        end
    end

    assign o_ready = (r_st != ST_FULL);
    assign o_valid = (r_st != ST_EMPTY);
    assign o_bus   = r_main;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush, bubble zeroing and stall counter.
// Define PIPE_SKID_BUF_EN for the two-entry registered-ready variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = ID_EX_CTRL_W,
    parameter int DATA_W   = ID_EX_DATA_W,
    parameter bit CLR_DATA = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [CNT_W-1:0] r_stall;
    logic w_stall;

`ifdef PIPE_SKID_BUF_EN
    logic [CTRL_W+DATA_W-1:0] w_bus;
    logic w_valid;

    pipe_skid_buf #(
        .W   (CTRL_W + DATA_W),
        .CLR (CLR_DATA)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_bus   ({in_ctrl, in_data}),
        .o_valid (w_valid),
        .i_ready (out_ready),
        .o_bus   (w_bus)
    );

    // main entry keeps stale control after drain/flush; mask it here
    assign out_valid = w_valid;
    assign out_ctrl  = w_valid ? w_bus[CTRL_W+DATA_W-1:DATA_W] : '0;
    assign out_data  = w_bus[DATA_W-1:0];
`else
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic w_acc;
    logic w_drn;

    assign in_ready = ~r_valid | out_ready;
    assign w_acc    = in_valid & in_ready;
    assign w_drn    = r_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (CLR_DATA) begin
                r_data <= '0;
            end
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
        end else if (w_drn) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_data  = r_data;
`endif

    assign w_stall = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall;

endmodule
